// File: rtl/priority_encoder_8to3_sync.sv
// -----------------------------------------------------------------------------
// priority_encoder_8to3_sync
//
// Registered 8-input priority encoder. Reduces a request vector to the binary
// index of its highest-numbered set bit, plus a flag saying whether any bit
// was set. The encode is purely combinational and feeds a single output
// register stage, so there is no combinational path from i to the outputs.
//
// Ports:
//   clk    in   1  system clock, rising-edge active
//   rst    in   1  synchronous, active-high reset (has priority over en)
//   en     in   1  capture enable; 0 holds out/valid
//   i      in   8  request vector, bit 7 highest priority
//   out    out  3  registered index of highest set bit of i
//   valid  out  1  registered "any bit set" flag
//
// out == 3'b000 means either "bit 0 set" or "nothing set"; consumers must
// qualify out with valid.
// -----------------------------------------------------------------------------
module priority_encoder_8to3_sync #(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] i,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    // The casez table below is written for exactly 8 inputs / 3 index bits.
    generate
        if (WIDTH != 8 || OUT_W != 3) begin : g_bad_params
            $error("priority_encoder_8to3_sync supports only WIDTH=8, OUT_W=3");
        end
    endgenerate

    logic [OUT_W-1:0] idx;
    logic             any;

    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    // Highest set bit wins; the default branch covers i == 0 and also keeps
    // the block latch-free.
    always_comb begin
        idx = 3'b000;
        any = 1'b0;
        casez (i)
            8'b1???????: begin idx = 3'd7; any = 1'b1; end
            8'b01??????: begin idx = 3'd6; any = 1'b1; end
            8'b001?????: begin idx = 3'd5; any = 1'b1; end
            8'b0001????: begin idx = 3'd4; any = 1'b1; end
            8'b00001???: begin idx = 3'd3; any = 1'b1; end
            8'b000001??: begin idx = 3'd2; any = 1'b1; end
            8'b0000001?: begin idx = 3'd1; any = 1'b1; end
            8'b00000001: begin idx = 3'd0; any = 1'b1; end
            default:     begin idx = 3'd0; any = 1'b0; end
        endcase
    end

    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        if (en) begin
            out_d   = idx;
            valid_d = any;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_8to3_sync.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_8to3_sync
//
// Directed bench for priority_encoder_8to3_sync. Inputs change on the falling
// edge; outputs are checked just before the next rising edge (must still show
// the previous result) and 1 ns after it (must show the new result).
// -----------------------------------------------------------------------------
module tb_priority_encoder_8to3_sync;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] i;
    logic [2:0] out;
    logic       valid;

    int errors = 0;
    int checks = 0;

    logic [2:0] exp_out_prev;
    logic       exp_valid_prev;
    bit         have_prev = 0;

    priority_encoder_8to3_sync #(.WIDTH(8), .OUT_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .i     (i),
        .out   (out),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Independent reference: scan bits from low to high, keep the last one set.
    function automatic logic [3:0] ref_model(input logic [7:0] v);
        logic [2:0] ix;
        logic       a;
        ix = 3'd0;
        a  = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (v[b]) begin
                ix = 3'(b);
                a  = 1'b1;
            end
        end
        return {a, ix};
    endfunction

    // Apply one vector for one clock and check both sides of the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic [7:0] v,
                        input logic [2:0] eo, input logic ev);
        @(negedge clk);
        rst = r;
        en  = e;
        i   = v;
        #1;
        if (have_prev)
            check({tag, "_pre"}, {valid, out}, {exp_valid_prev, exp_out_prev});
        @(posedge clk);
        #1;
        check(tag, {valid, out}, {ev, eo});
        exp_out_prev   = eo;
        exp_valid_prev = ev;
        have_prev      = 1;
    endtask

    initial begin
        logic [3:0] r;
        rst = 1'b1;
        en  = 1'b1;
        i   = 8'hFF;

        // 1. reset with all requests and enable active
        step("reset0", 1'b1, 1'b1, 8'hFF, 3'b000, 1'b0);
        step("reset1", 1'b1, 1'b1, 8'hFF, 3'b000, 1'b0);

        // 2. zero and single bits
        step("zero",  1'b0, 1'b1, 8'b00000000, 3'b000, 1'b0);
        step("bit0",  1'b0, 1'b1, 8'b00000001, 3'b000, 1'b1);
        step("bit1",  1'b0, 1'b1, 8'b00000010, 3'b001, 1'b1);
        step("bit2",  1'b0, 1'b1, 8'b00000100, 3'b010, 1'b1);
        step("bit3",  1'b0, 1'b1, 8'b00001000, 3'b011, 1'b1);
        step("bit7",  1'b0, 1'b1, 8'b10000000, 3'b111, 1'b1);

        // 3. multiple bits
        step("multi3e", 1'b0, 1'b1, 8'b00111110, 3'b101, 1'b1);
        step("multiff", 1'b0, 1'b1, 8'b11111111, 3'b111, 1'b1);
        step("multi55", 1'b0, 1'b1, 8'b01010101, 3'b110, 1'b1);

        // 4. enable hold
        step("cap3",  1'b0, 1'b1, 8'b00001000, 3'b011, 1'b1);
        step("hold0", 1'b0, 1'b0, 8'b10000000, 3'b011, 1'b1);
        step("hold1", 1'b0, 1'b0, 8'b10000000, 3'b011, 1'b1);
        step("hold2", 1'b0, 1'b0, 8'b10000000, 3'b011, 1'b1);
        step("reen",  1'b0, 1'b1, 8'b10000000, 3'b111, 1'b1);
        // hold with zero vector must not clear valid
        step("holdz", 1'b0, 1'b0, 8'b00000000, 3'b111, 1'b1);

        // 5. reset mid-stream
        step("pre_rst", 1'b0, 1'b1, 8'b00111110, 3'b101, 1'b1);
        step("mid_rst", 1'b1, 1'b1, 8'hFF,       3'b000, 1'b0);
        step("post_rst",1'b0, 1'b1, 8'hFF,       3'b111, 1'b1);
        // reset wins even with en=0
        step("rst_noen",1'b1, 1'b0, 8'hFF,       3'b000, 1'b0);

        // 6. exhaustive sweep, one vector per cycle
        for (int v = 0; v < 256; v++) begin
            r = ref_model(8'(v));
            step($sformatf("sweep_%02h", v), 1'b0, 1'b1, 8'(v), r[2:0], r[3]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
